postproc_stream: RTL
====================

// Module: postproc_stream
// PURPOSE
// - Streaming stereo post-processor: left-right consistency check (LRC) plus hole filling in one pipelined block.
// - Sits after SGM aggregation/WTA; consumes per-pixel L and R disparities in raster order and emits one filtered disparity per pixel.
// - Adds to the previous generation: parametrised widths, internal R line buffer, runtime fill modes, and valid/ready input backpressure.
// PARAMETERS
// - DWIDTH    8     disparity bits; all-ones (INVALID) marks an invalid pixel
// - AWIDTH    11    pixel-index bits
// - MAX_WIDTH 2048  R line-buffer depth; width must be <= MAX_WIDTH
// PORTS
// - clk        in   1       clock
// - rst        in   1       asynchronous, active-high reset
// - clken      in   1       global enable; 0 freezes all state, so no transfers occur
// - width      in   AWIDTH  line width (>=1); sampled when x==0 is accepted
// - range      in   DWIDTH  LRC tolerance
// - mode       in   2       0 pass (invalid pixels -> INVALID), 1 fill-left, 2 fill min(left,right), 3 fill max(left,right)
// - in_valid   in   1       input pixel valid
// - in_ready   out  1       input accept; a transfer needs in_valid & in_ready & clken
// - in_disp_L  in   DWIDTH  left disparity dL[x]
// - in_disp_R  in   DWIDTH  right disparity dR[x]
// - out_valid  out  1       output valid; downstream never stalls and qualifies this with clken
// - out_disp   out  DWIDTH  filtered disparity
// - out_filled out  1       1 = value was substituted by hole filling
// - out_eol    out  1       last output pixel of the line
// BEHAVIOUR
// - Reset: x=0, pending=0, LV (last valid) empty, state STREAM, pipeline empty; out_valid/out_filled/out_eol=0, out_disp=0, in_ready=0.
// - S0 (accept cycle t):
//   - write dR[x] into the R buffer at address x;
//   - issue a read at xr = x - dL;
//   - x wraps to 0 after width-1.
// - S1 (t+1): pixel is valid iff dL != INVALID, xr >= 0 (signed compare, AWIDTH+1 bits), and |dL - R[xr]| <= range.
//   - When dL==0 (xr==x, read during write), bypass the value being written.
// - S2 hole-filler FSM, output registered: a valid pixel with no pending holes appears at t+2.
//   - in_ready = clken & (!S1_valid | state==STREAM).
// - STREAM, pixel valid, pending==0: emit dL with filled=0; LV := dL.
// - STREAM, pixel invalid:
//   - mode 0: emit INVALID, filled=0.
//   - mode 1 with LV present: emit LV, filled=1.
//   - otherwise: pending++ and emit nothing.
// - STREAM, pixel valid, pending>0 -> FLUSH:
//   - emit pending words of F = min(LV,dL) (mode 2), max(LV,dL) (mode 3), or dL (LV empty, or mode 1), each filled=1;
//   - then emit dL; return to STREAM. Input stalls for pending cycles.
// - Last pixel of the line (x==width-1) with pending>0 after S1 -> EOL_FLUSH:
//   - emit pending words of LV, or INVALID if LV is empty, with filled=1 when LV exists (0 otherwise);
//   - out_eol on the final word.
// - out_eol is asserted on exactly one word per line. Each line emits exactly width outputs.
//   - At EOL: pending:=0, LV emptied, x:=0.
// - pending is AWIDTH+1 bits and cannot overflow because pending <= width.
// - mode and range are sampled per pixel in S1/S2; a mode change mid-run uses the mode current at flush time.
// - clken=0 during FLUSH/EOL_FLUSH: freeze the count; do not repeat or skip words.
// - Async rst mid-line or mid-flush: all state clears immediately; the next accepted pixel is x=0 of a new line.
// - A width change takes effect only at line start.
// STRUCTURE
// - Shared package pp_pkg: FSM encodings STREAM/FLUSH/EOL_FLUSH, mode encodings, INVALID = {DWIDTH{1'b1}}.
// - Sub-module lrc_line_buffer: MAX_WIDTH x DWIDTH register-array RAM, 1 write + 1 synchronous read, with same-address write-to-read bypass.
// - LRC compare and hole-filler FSM live in this module.
// TESTING
// - Common setup for the first three: width=6, range=7, R=[0,0,0,0,0,0], L=[0,1,7,7,4,0].
// - mode 2 -> out 0,1,1,1,4,0; filled=0,0,1,1,0,0; in_ready low 2 cycles when x=4 is in S2; eol on the 6th word.
// - Same stimulus, mode 3 -> 0,1,4,4,4,0. mode 1 -> 0,1,1,1,4,0 with no stall. mode 0 -> 0,1,FF,FF,4,0.
// - width=4, range=1, mode 0, L=[0,0,0,0], R=[0,2,1,0] -> 0,FF,0,0; exercises the dL==0 bypass at x=1.
// - width=4, range=7, mode 2, R=0:
//   - L=[3,3,3,1] -> 1,1,1,1 with filled=1,1,1,0;
//   - L=[7,7,7,7] -> FF x4, filled=0, eol on the 4th word.
// - Assert rst for 1 cycle mid-FLUSH, then send a new width=6 line -> out_valid drops at once and the new line outputs exactly 6 words with correct values.
// - clken low 3 cycles during FLUSH -> output sequence identical to the run without clken gaps, no duplicated or dropped words.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared encodings for the stereo post-processor: hole-filler states, fill modes
// and default geometry.
package pp_pkg;

  localparam int DWIDTH_DEF    = 8;
  localparam int AWIDTH_DEF    = 11;
  localparam int MAX_WIDTH_DEF = 2048;

  typedef enum logic [1:0] {
    STREAM    = 2'd0,
    FLUSH     = 2'd1,
    EOL_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_FILL_LEFT = 2'd1,
    MODE_FILL_MIN  = 2'd2,
    MODE_FILL_MAX  = 2'd3
  } mode_t;

endpackage

// File: rtl/postproc_stream_lrc_line_buffer.sv
// Right-disparity line store: one write port, one synchronous read port, with
// the word being written forwarded when both ports hit the same address.
module lrc_line_buffer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without reset so it maps onto
  // plain RAM; every location is written before it is read within a line.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/postproc_stream.sv
// Streaming left-right consistency check plus hole filling: S0 accepts and looks
// up R, S1 validates the pixel, S2 is the hole-filler FSM with registered output.
module postproc_stream
  import pp_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic [DWIDTH-1:0] range,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_disp_L,
  input  logic [DWIDTH-1:0] in_disp_R,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_disp,
  output logic              out_filled,
  output logic              out_eol
);

  localparam logic [DWIDTH-1:0] INVALID = {DWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] X_ONE   = AWIDTH'(1);
  localparam logic [AWIDTH:0]   P_ONE   = (AWIDTH+1)'(1);

  state_t            state;
  logic [AWIDTH-1:0] x;
  logic [AWIDTH-1:0] line_width;
  logic [AWIDTH-1:0] cur_width;
  logic [AWIDTH:0]   xr;
  logic              xfer;
  logic              at_last;

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_dl;
  logic              s1_xr_neg;
  logic              s1_eol;
  logic [DWIDTH-1:0] rd_data;

  logic [AWIDTH:0]   pending;
  logic [AWIDTH:0]   cnt;
  logic [DWIDTH-1:0] lv;
  logic              lv_ok;
  logic [DWIDTH-1:0] hold_disp;
  logic              hold_eol;

  logic [DWIDTH-1:0] diff;
  logic              pix_ok;
  logic [DWIDTH-1:0] flush_dl;
  logic [DWIDTH-1:0] fill_disp;
  logic              fill_filled;
  logic [DWIDTH-1:0] eol_disp;

  // S1 can only hand its pixel on while the filler is streaming.
  assign in_ready  = clken & ~rst & (~s1_valid | (state == STREAM));
  assign xfer      = in_valid & in_ready;
  assign cur_width = (x == '0) ? width : line_width;
  assign at_last   = (x == (cur_width - X_ONE));
  assign xr        = {1'b0, x} - (AWIDTH+1)'(in_disp_L);

  lrc_line_buffer #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .DEPTH  (MAX_WIDTH)
  ) u_rbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer),
    .wr_addr (x),
    .wr_data (in_disp_R),
    .rd_en   (xfer),
    .rd_addr (xr[AWIDTH-1:0]),
    .rd_data (rd_data)
  );

  // NOTE: sequential state is assigned with <= so every register in the block
  // sees the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      line_width <= '0;
      s1_valid   <= 1'b0;
      s1_dl      <= '0;
      s1_xr_neg  <= 1'b0;
      s1_eol     <= 1'b0;
    end else if (clken) begin
      if (xfer) begin
        line_width <= cur_width;
        x          <= at_last ? '0 : x + X_ONE;
        s1_valid   <= 1'b1;
        s1_dl      <= in_disp_L;
        s1_xr_neg  <= xr[AWIDTH];
        s1_eol     <= at_last;
      end else if (state == STREAM) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    diff        = (s1_dl >= rd_data) ? (s1_dl - rd_data) : (rd_data - s1_dl);
    pix_ok      = (s1_dl != INVALID) && !s1_xr_neg && (diff <= range);
    flush_dl    = (state == STREAM) ? s1_dl : hold_disp;
    fill_disp   = flush_dl;
    fill_filled = 1'b1;
    case (mode_t'(mode))
      MODE_PASS: begin
        fill_disp   = INVALID;
        fill_filled = 1'b0;
      end
      MODE_FILL_MIN: if (lv_ok) fill_disp = (lv < flush_dl) ? lv : flush_dl;
      MODE_FILL_MAX: if (lv_ok) fill_disp = (lv > flush_dl) ? lv : flush_dl;
      default: ;
    endcase
    eol_disp = lv_ok ? lv : INVALID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STREAM;
      pending    <= '0;
      cnt        <= '0;
      lv         <= '0;
      lv_ok      <= 1'b0;
      hold_disp  <= '0;
      hold_eol   <= 1'b0;
      out_valid  <= 1'b0;
      out_disp   <= '0;
      out_filled <= 1'b0;
      out_eol    <= 1'b0;
    end else if (clken) begin
      out_valid  <= 1'b0;
      out_filled <= 1'b0;
      out_eol    <= 1'b0;
      case (state)
        STREAM: if (s1_valid) begin
          if (pix_ok && (pending == '0)) begin
            out_valid <= 1'b1;
            out_disp  <= s1_dl;
            out_eol   <= s1_eol;
            lv        <= s1_dl;
            lv_ok     <= !s1_eol;
          end else if (pix_ok) begin
            out_valid  <= 1'b1;
            out_disp   <= fill_disp;
            out_filled <= fill_filled;
            hold_disp  <= s1_dl;
            hold_eol   <= s1_eol;
            cnt        <= pending - P_ONE;
            pending    <= '0;
            state      <= FLUSH;
          end else if ((pending == '0) && (mode_t'(mode) == MODE_PASS)) begin
            out_valid <= 1'b1;
            out_disp  <= INVALID;
            out_eol   <= s1_eol;
            if (s1_eol) lv_ok <= 1'b0;
          end else if ((pending == '0) && (mode_t'(mode) == MODE_FILL_LEFT) && lv_ok) begin
            out_valid  <= 1'b1;
            out_disp   <= lv;
            out_filled <= 1'b1;
            out_eol    <= s1_eol;
            if (s1_eol) lv_ok <= 1'b0;
          end else if (s1_eol) begin
            // Line ends on a hole: this pixel plus all pending holes close the line.
            out_valid  <= 1'b1;
            out_disp   <= eol_disp;
            out_filled <= lv_ok;
            pending    <= '0;
            if (pending == '0) begin
              out_eol <= 1'b1;
              lv_ok   <= 1'b0;
            end else begin
              cnt   <= pending;
              state <= EOL_FLUSH;
            end
          end else begin
            pending <= pending + P_ONE;
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          if (cnt != '0) begin
            out_disp   <= fill_disp;
            out_filled <= fill_filled;
            cnt        <= cnt - P_ONE;
          end else begin
            out_disp <= hold_disp;
            out_eol  <= hold_eol;
            lv       <= hold_disp;
            lv_ok    <= !hold_eol;
            state    <= STREAM;
          end
        end
        EOL_FLUSH: begin
          out_valid  <= 1'b1;
          out_disp   <= eol_disp;
          out_filled <= lv_ok;
          cnt        <= cnt - P_ONE;
          if (cnt == P_ONE) begin
            out_eol <= 1'b1;
            lv_ok   <= 1'b0;
            state   <= STREAM;
          end
        end
        default: state <= STREAM;
      endcase
    end
  end

endmodule
